// File: rtl/scs8hd_clkdiv_gate.sv
// ============================================================================
//  Module   : scs8hd_clkdiv_gate
//  Brief    : NCH-channel 50%-duty clock divider with glitch-free enable and
//             boundary-synchronised ratio update (UPD/ACK handshake).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scs8hd_clkdiv_gate #(
    parameter int NCH     = 4,
    parameter int CNTW    = 8,
    parameter int RST_DIV = 0
) (
    input  logic                CLK,
    input  logic                RESETB,
    input  logic [NCH-1:0]      EN,
    input  logic [NCH*CNTW-1:0] DIV,
    input  logic [NCH-1:0]      UPD,
    output logic [NCH-1:0]      X,
    output logic [NCH-1:0]      RUN,
    output logic [NCH-1:0]      ACK
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] c_RST_DIV = CNTW'(RST_DIV);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        state_t          r_state;
        state_t          w_state_nxt;
        logic [CNTW-1:0] r_cnt;
        logic [CNTW-1:0] w_cnt_nxt;
        logic [CNTW-1:0] r_div_act;
        logic [CNTW-1:0] w_div_act_nxt;
        logic [CNTW-1:0] r_div_pend;
        logic [CNTW-1:0] w_div_pend_nxt;
        logic            r_pend;
        logic            w_pend_nxt;
        logic            r_x;
        logic            w_x_nxt;
        logic            r_ack;
        logic            w_ack_nxt;
        logic [CNTW-1:0] w_div_in;
        logic            w_wrap;

        assign w_div_in = DIV[gi*CNTW +: CNTW];
        assign w_wrap   = (r_cnt == r_div_act);

        always_comb begin
            w_state_nxt    = r_state;
            w_cnt_nxt      = r_cnt;
            w_div_act_nxt  = r_div_act;
            w_div_pend_nxt = r_div_pend;
            w_pend_nxt     = r_pend;
            w_x_nxt        = r_x;
            w_ack_nxt      = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_x_nxt    = 1'b0;
                    w_cnt_nxt  = '0;
                    w_pend_nxt = 1'b0;
                    // A same-cycle UPD is loaded directly so the first period uses it.
                    if (UPD[gi]) begin
                        w_div_act_nxt = w_div_in;
                        w_ack_nxt     = 1'b1;
                    end
                    if (EN[gi]) begin
                        w_x_nxt     = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (UPD[gi]) begin
                        w_div_pend_nxt = w_div_in;
                        w_pend_nxt     = 1'b1;
                    end
                    if (!w_wrap) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else begin
                        w_cnt_nxt = '0;
                        if (r_x) begin
                            w_x_nxt = 1'b0;
                        end else begin
                            // Period boundary: the only point where ratio and run state may change.
                            if (UPD[gi]) begin
                                w_div_act_nxt = w_div_in;
                                w_ack_nxt     = 1'b1;
                            end else if (r_pend) begin
                                w_div_act_nxt = r_div_pend;
                                w_ack_nxt     = 1'b1;
                            end
                            w_pend_nxt = 1'b0;
                            if (EN[gi]) begin
                                w_x_nxt = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
            endcase
        end

        always_ff @(posedge CLK or negedge RESETB) begin
            if (!RESETB) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_div_act  <= c_RST_DIV;
                r_div_pend <= '0;
                r_pend     <= 1'b0;
                r_x        <= 1'b0;
                r_ack      <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_cnt      <= w_cnt_nxt;
                r_div_act  <= w_div_act_nxt;
                r_div_pend <= w_div_pend_nxt;
                r_pend     <= w_pend_nxt;
                r_x        <= w_x_nxt;
                r_ack      <= w_ack_nxt;
            end
        end

        assign X[gi]   = r_x;
        assign RUN[gi] = (r_state == ST_RUN);
        assign ACK[gi] = r_ack;
    end

endmodule

`default_nettype wire

// File: tb/tb_scs8hd_clkdiv_gate.sv
// ============================================================================
//  Module   : tb_scs8hd_clkdiv_gate
//  Brief    : Directed self-checking bench for scs8hd_clkdiv_gate.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scs8hd_clkdiv_gate;

    localparam int NCH  = 4;
    localparam int CNTW = 8;

    logic                CLK;
    logic                RESETB;
    logic [NCH-1:0]      EN;
    logic [NCH*CNTW-1:0] DIV;
    logic [NCH-1:0]      UPD;
    logic [NCH-1:0]      X;
    logic [NCH-1:0]      RUN;
    logic [NCH-1:0]      ACK;

    int n_chk  = 0;
    int n_pass = 0;

    scs8hd_clkdiv_gate #(
        .NCH     (NCH),
        .CNTW    (CNTW),
        .RST_DIV (0)
    ) dut (
        .CLK    (CLK),
        .RESETB (RESETB),
        .EN     (EN),
        .DIV    (DIV),
        .UPD    (UPD),
        .X      (X),
        .RUN    (RUN),
        .ACK    (ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Bit k of xp/ap holds X[ch]/ACK[ch] just after the k-th following edge.
    task automatic cap(input int n, input int ch, output logic [63:0] xp, output logic [63:0] ap);
        xp = '0;
        ap = '0;
        for (int k = 0; k < n; k++) begin
            tick();
            xp[k] = X[ch];
            ap[k] = ACK[ch];
        end
    endtask

    initial begin
        logic [63:0] xp;
        logic [63:0] ap;
        int          err [NCH];
        int          dv  [NCH];
        logic        e;

        RESETB = 1'b0;
        EN     = '0;
        DIV    = '0;
        UPD    = '0;
        tick();
        tick();
        chk("reset X", X, 4'h0);
        chk("reset RUN", RUN, 4'h0);
        chk("reset ACK", ACK, 4'h0);
        RESETB = 1'b1;

        // RST_DIV=0: CLK/2 on channel 0
        tick();
        chk("idle X", X, 4'h0);
        EN = 4'b0001;
        tick();
        chk("en X rise", X, 4'b0001);
        chk("en RUN", RUN, 4'b0001);
        cap(4, 0, xp, ap);
        chk("div0 X pattern", xp, 64'hA);
        chk("div0 ACK quiet", ap, 64'h0);
        EN = 4'b0000;
        tick();
        tick();
        chk("div0 stop X", X, 4'h0);
        chk("div0 stop RUN", RUN, 4'h0);

        // IDLE update to 3, then run
        DIV = 32'h0000_0003;
        UPD = 4'b0001;
        tick();
        chk("idle upd ACK", ACK, 4'b0001);
        chk("idle upd X", X, 4'h0);
        UPD = 4'b0000;
        EN  = 4'b0001;
        cap(8, 0, xp, ap);
        chk("div3 X pattern", xp, 64'h0F);
        chk("div3 ACK", ap, 64'h00);

        // Running update 3 -> 1 mid high phase
        tick();
        tick();
        DIV = 32'h0000_0001;
        UPD = 4'b0001;
        tick();
        UPD = 4'b0000;
        DIV = 32'h0000_0007;
        cap(10, 0, xp, ap);
        chk("run upd X pattern", xp, 64'h261);
        chk("run upd ACK", ap, 64'h020);

        // Two updates before one boundary: last wins, single ACK
        DIV = 32'h0000_0005;
        UPD = 4'b0001;
        tick();
        DIV = 32'h0000_0001;
        tick();
        UPD = 4'b0000;
        DIV = 32'h0000_0009;
        cap(8, 0, xp, ap);
        chk("dbl upd X pattern", xp, 64'h66);
        chk("dbl upd ACK", ap, 64'h02);

        EN = 4'b0000;
        cap(2, 0, xp, ap);
        chk("stop X", xp, 64'h0);
        chk("stop RUN", RUN, 4'h0);

        // div 2 with UPD+EN together, EN dropped at second high cycle
        DIV = 32'h0000_0002;
        UPD = 4'b0001;
        EN  = 4'b0001;
        tick();
        chk("upd+en ACK", ACK, 4'b0001);
        chk("upd+en X", X, 4'b0001);
        UPD = 4'b0000;
        tick();
        EN = 4'b0000;
        cap(6, 0, xp, ap);
        chk("en drop X pattern", xp, 64'h01);
        chk("en drop RUN", RUN, 4'h0);

        // EN dropped and re-raised before the boundary
        EN = 4'b0001;
        tick();
        tick();
        EN = 4'b0000;
        tick();
        tick();
        EN = 4'b0001;
        cap(8, 0, xp, ap);
        chk("en reraise X pattern", xp, 64'h1C);
        chk("en reraise RUN", RUN, 4'b0001);
        EN = 4'b0000;
        tick();
        tick();
        chk("idle before multi", RUN, 4'h0);

        // Four channels concurrently: DIV = {255,2,1,0}
        dv  = '{0, 1, 2, 255};
        err = '{0, 0, 0, 0};
        DIV = 32'hFF02_0100;
        UPD = 4'hF;
        EN  = 4'hF;
        for (int k = 0; k < 520; k++) begin
            tick();
            if (k == 0) begin
                chk("multi ACK", ACK, 4'hF);
                UPD = 4'h0;
            end
            for (int c = 0; c < NCH; c++) begin
                e = (((k / (dv[c] + 1)) % 2) == 0);
                if (X[c] !== e) err[c]++;
            end
        end
        chk("multi ch0 errs", err[0], 0);
        chk("multi ch1 errs", err[1], 0);
        chk("multi ch2 errs", err[2], 0);
        chk("multi ch3 errs", err[3], 0);

        // Pending update on ch3, then asynchronous reset mid high phase
        DIV = 32'h0900_0000;
        UPD = 4'b1000;
        tick();
        UPD = 4'b0000;
        chk("pre-reset X3", X[3], 1'b1);
        #2;
        RESETB = 1'b0;
        #1;
        chk("async reset X", X, 4'h0);
        chk("async reset RUN", RUN, 4'h0);
        chk("async reset ACK", ACK, 4'h0);
        EN = 4'b0000;
        tick();
        tick();
        RESETB = 1'b1;
        tick();
        chk("post-reset ACK", ACK, 4'h0);
        EN = 4'b1000;
        cap(6, 3, xp, ap);
        chk("post-reset X3 pattern", xp, 64'h15);
        chk("post-reset ACK3", ap, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scs8hd_clkdiv_gate.md
# scs8hd_clkdiv_gate

Parametrised multi-channel clock divider and glitch-free gate. It derives NCH independent divided clocks from CLK, each with 50% duty and a programmable ratio. Each channel has its own enable and a request/acknowledge ratio-update handshake. It sits after the clock-buffer cells and drives per-domain clock trees. Enable changes and ratio changes take effect only at period boundaries, so no output ever produces a runt pulse.

## Interface
Parameters:
- NCH, 4, number of independent output channels (1..16)
- CNTW, 8, width of the per-channel divide field and counter
- RST_DIV, 0, divide value loaded into every channel at reset (must fit in CNTW bits)

Ports:
- CLK  input  1  source clock; all state changes on its rising edge
- RESETB  input  1  asynchronous, active-low reset
- EN  input  NCH  per-channel run request, level sensitive
- DIV  input  NCH*CNTW  per-channel divide value; channel i uses bits [i*CNTW +: CNTW]
- UPD  input  NCH  per-channel ratio-update request, sampled high on a CLK edge
- X  output  NCH  divided clock outputs, registered
- RUN  output  NCH  1 while the channel is in state RUN
- ACK  output  NCH  one-cycle pulse when a requested DIV value has been applied

## Operation
Per-channel state: fsm (IDLE/RUN), cnt[CNTW], div_act[CNTW], div_pend[CNTW], pend, X, ACK.

Reset (RESETB low, asynchronous) sets every channel to:
- fsm=IDLE
- X=0, RUN=0, ACK=0
- cnt=0
- div_act=RST_DIV
- pend=0

IDLE:
- X held 0, cnt held 0.
- UPD[i]=1: div_act <= DIV slice; ACK[i]=1 in the next cycle. No pending state is used.
- EN[i]=1: X <= 1, cnt <= 0, fsm <= RUN. If UPD and EN are high in the same cycle, the new DIV is used for the first period.

RUN:
- If cnt != div_act: cnt <= cnt+1.
- If cnt == div_act: cnt <= 0 and X toggles.
- X is high for div_act+1 cycles, then low for div_act+1 cycles, giving period 2*(div_act+1).
- Boundary = cycle with X=0 and cnt==div_act. At the boundary:
  - If pend (or UPD high this cycle): div_act <= pending (or current) DIV, pend <= 0, ACK pulses next cycle.
  - If EN[i]=0: fsm <= IDLE, X stays 0.
  - Otherwise X <= 1 and a new period starts.
- UPD[i]=1 outside a boundary: div_pend <= DIV slice, pend <= 1. Repeated UPD before the boundary overwrites div_pend (last wins) and yields a single ACK.
- EN deasserted mid-period: the current period completes in full and is never truncated. EN re-asserted before the boundary: no gap, continuous output.
- DIV changes without UPD are ignored.

Channels are fully independent. There is no phase relation between channels except through shared EN timing.

Width rules:
- cnt and div_act are CNTW bits, unsigned.
- Maximum period is 2^(CNTW+1) CLK cycles.
- Minimum period (div 0) is CLK/2.

## Timing
- X, RUN and ACK are flop outputs with no combinational path from any input.
- EN rise in IDLE to X rise: 1 cycle.
- Stop latency: X falls at its normal time, and the channel is in IDLE at the edge following the boundary.
- ACK: exactly one cycle high, in the cycle after div_act is loaded.
- UPD-to-ACK latency:
  - IDLE: 1 cycle.
  - RUN: cycles remaining to the boundary, plus 1.
- RESETB assertion mid-period forces X=0 immediately. This is the only path that may shorten a pulse, and it is accepted.
- After RESETB deassertion, EN must be held at least 1 cycle before X rises.

## Test plan
- Reset, RST_DIV=0, EN[0]=1 from cycle 2 -> X[0] rises at cycle 3, toggles every cycle (CLK/2), RUN[0]=1; all other outputs stay 0.
- IDLE, DIV slice 0 = 3, UPD[0] pulse, then EN[0]=1 -> ACK[0] one cycle after UPD; X[0] 4 high / 4 low, period 8.
- Running with div_act=3, UPD[0] with DIV=1 at cnt=1 of the high phase -> current period finishes at 8 cycles, ACK[0] the cycle after the boundary, following periods 4 cycles. Two UPDs (DIV=5, then 1) before the boundary -> one ACK, ratio 1.
- div_act=2, EN[0] dropped at the second high cycle -> X[0] completes 3 high + 3 low, then stays 0 and RUN[0]=0. EN dropped then re-raised before the boundary -> no missing period.
- NCH=4 with DIV={0,1,2,255}, all enabled together -> periods of 2, 4, 6 and 512 cycles, verified concurrently and each at 50% duty.
- RESETB pulsed low mid high-phase -> X, RUN and ACK go to 0 immediately, div_act returns to RST_DIV, and the pending update is discarded (no ACK).
